// File: rtl/data_mem_arb_if.sv
// Request/response bundle between one data-memory master and the arbiter.
interface data_mem_arb_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/data_mem_arb.sv
// Round-robin arbiter merging two masters onto the single-port data RAM.
// Tracks each accepted access through the RAM's one-cycle read latency,
// steers the response to its owner and holds the last read data per master.
module data_mem_arb #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    data_mem_arb_if.slave             m0,
    data_mem_arb_if.slave             m1,
    output logic                      mem_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    // Arbitration and response state
    owner_e                last_gnt, last_gnt_d;
    logic                  rsp_valid, rsp_valid_d;
    owner_e                rsp_owner, rsp_owner_d;
    logic                  rsp_we, rsp_we_d;
    logic [DATA_WIDTH-1:0] hold0, hold0_d;
    logic [DATA_WIDTH-1:0] hold1, hold1_d;

    logic gnt0, gnt1;
    logic rd_rsp0, rd_rsp1;

    // Grant selection: lone requester wins, contention goes to the master not granted last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0.req && m1.req) begin
                gnt0 = (last_gnt == OWNER_M1);
                gnt1 = (last_gnt == OWNER_M0);
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    // Memory request mux; all fields idle at zero when nobody is granted
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_addr  = m0.addr;
            mem_we    = m0.we;
            mem_be    = m0.be;
            mem_wdata = m0.wdata;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_addr  = m1.addr;
            mem_we    = m1.we;
            mem_be    = m1.be;
            mem_wdata = m1.wdata;
        end
    end

    // Read responses in flight this cycle, per master
    always_comb begin
        rd_rsp0 = rsp_valid && (rsp_owner == OWNER_M0) && !rsp_we;
        rd_rsp1 = rsp_valid && (rsp_owner == OWNER_M1) && !rsp_we;
    end

    // Master-facing grant and response outputs; read data passes through on its response cycle
    always_comb begin
        m0.gnt    = gnt0;
        m1.gnt    = gnt1;
        m0.rvalid = rsp_valid && (rsp_owner == OWNER_M0);
        m1.rvalid = rsp_valid && (rsp_owner == OWNER_M1);
        m0.rdata  = rd_rsp0 ? mem_rdata : hold0;
        m1.rdata  = rd_rsp1 ? mem_rdata : hold1;
    end

    // Next-state: record the accepted access and capture read data into the owner's hold register
    always_comb begin
        last_gnt_d  = last_gnt;
        rsp_valid_d = gnt0 || gnt1;
        rsp_owner_d = rsp_owner;
        rsp_we_d    = rsp_we;
        hold0_d     = hold0;
        hold1_d     = hold1;
        if (gnt0) begin
            last_gnt_d  = OWNER_M0;
            rsp_owner_d = OWNER_M0;
            rsp_we_d    = m0.we;
        end else if (gnt1) begin
            last_gnt_d  = OWNER_M1;
            rsp_owner_d = OWNER_M1;
            rsp_we_d    = m1.we;
        end
        if (rd_rsp0) begin
            hold0_d = mem_rdata;
        end
        if (rd_rsp1) begin
            hold1_d = mem_rdata;
        end
    end

    // State registers; reset drops any pending response and restores m0 priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= OWNER_M1;
            rsp_valid <= 1'b0;
            rsp_owner <= OWNER_M0;
            rsp_we    <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            last_gnt  <= last_gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_owner <= rsp_owner_d;
            rsp_we    <= rsp_we_d;
            hold0     <= hold0_d;
            hold1     <= hold1_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arb.sv
// Self-checking bench for data_mem_arb: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_data_mem_arb;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          req;
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } req_t;

    logic          clk;
    logic          rst;
    logic          preload;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    data_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    data_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

    data_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 32) return 32'hAAAAAAAA;
        return {8'(i), ~8'(i), 16'h5A00 | 16'(i)};
    endfunction

    // Synchronous RAM: one-cycle read latency, byte-enabled write committed at the edge
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] hold [2];
    int          ref_last;
    bit          rsp_v;
    int          rsp_own;
    bit          rsp_we;
    logic [31:0] rsp_data;
    int          win;
    req_t        cur [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_all();
        m0_if.req = cur[0].req; m0_if.addr = cur[0].addr; m0_if.we = cur[0].we;
        m0_if.be  = cur[0].be;  m0_if.wdata = cur[0].wdata;
        m1_if.req = cur[1].req; m1_if.addr = cur[1].addr; m1_if.we = cur[1].we;
        m1_if.be  = cur[1].be;  m1_if.wdata = cur[1].wdata;
    endtask

    function automatic req_t mk(input bit r, input int a, input bit w, input logic [3:0] be,
                                input logic [31:0] d);
        req_t t;
        t.req = r; t.addr = AW'(a); t.we = w; t.be = be; t.wdata = d;
        return t;
    endfunction

    task automatic model_reset();
        ref_last = 1;
        rsp_v    = 0;
        rsp_own  = 0;
        rsp_we   = 0;
        hold[0]  = '0;
        hold[1]  = '0;
        win      = -1;
    endtask

    // Predict grants, memory drive and responses for the current cycle and compare
    task automatic model_check();
        logic [52:0] exp_mem;
        logic [31:0] got_rd [2];
        bit          got_rv [2];
        bit          exp_rv;
        win = -1;
        if (!rst) begin
            if (cur[0].req && cur[1].req) win = (ref_last == 0) ? 1 : 0;
            else if (cur[0].req)          win = 0;
            else if (cur[1].req)          win = 1;
        end
        chk("m0_gnt", 64'(m0_if.gnt), 64'(win == 0));
        chk("m1_gnt", 64'(m1_if.gnt), 64'(win == 1));
        if (win >= 0) exp_mem = {1'b1, cur[win].addr, cur[win].we, cur[win].be, cur[win].wdata};
        else          exp_mem = '0;
        chk("mem_drive", 64'({mem_en, mem_addr, mem_we, mem_be, mem_wdata}), 64'(exp_mem));
        got_rv[0] = m0_if.rvalid; got_rv[1] = m1_if.rvalid;
        got_rd[0] = m0_if.rdata;  got_rd[1] = m1_if.rdata;
        for (int x = 0; x < 2; x++) begin
            exp_rv = rsp_v && (rsp_own == x);
            chk(x == 0 ? "m0_rvalid" : "m1_rvalid", 64'(got_rv[x]), 64'(exp_rv));
            chk(x == 0 ? "m0_rdata" : "m1_rdata", 64'(got_rd[x]),
                64'((exp_rv && !rsp_we) ? rsp_data : hold[x]));
        end
    endtask

    // Apply the clock edge to the model: retire the old response, accept the winner
    task automatic commit();
        if (rst) return;
        if (rsp_v && !rsp_we) hold[rsp_own] = rsp_data;
        rsp_v = 0;
        if (win >= 0) begin
            rsp_v   = 1;
            rsp_own = win;
            rsp_we  = cur[win].we;
            if (!cur[win].we) begin
                rsp_data = ref_mem[cur[win].addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (cur[win].be[b]) ref_mem[cur[win].addr[7:0]][8*b +: 8] = cur[win].wdata[8*b +: 8];
            end
            ref_last = win;
        end
    endtask

    // One cycle: called at the negedge with inputs driven; returns at the next negedge
    task automatic step();
        #2 model_check();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        cur[0] = mk(1, 5, 0, 4'hF, 0);
        cur[1] = mk(1, 6, 0, 4'hF, 0);
        drive_all();
        #1;
        chk("rst_m0_gnt", 64'(m0_if.gnt), 64'(0));
        chk("rst_m1_gnt", 64'(m1_if.gnt), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_m0_rdata", 64'(m0_if.rdata), 64'(0));
        chk("rst_m1_rvalid", 64'(m1_if.rvalid), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        cur[0].req = 0;
        cur[1].req = 0;
        drive_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        rst = 1'b1;
        preload = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        cur[0] = '0;
        cur[1] = '0;
        drive_all();
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single read from m0
        cur[0] = mk(1, 16'h0010, 0, 4'hF, 0);
        drive_all();
        #1 chk("single_gnt", 64'(m0_if.gnt), 64'(1));
        chk("single_addr", 64'(mem_addr), 64'(16'h0010));
        step();
        cur[0].req = 0;
        drive_all();
        chk("single_rvalid", 64'(m0_if.rvalid), 64'(1));
        chk("single_rdata", 64'(m0_if.rdata), 64'(32'hDEADBEEF));
        step();
        chk("single_hold", 64'(m0_if.rdata), 64'(32'hDEADBEEF));
        step();

        // Contention from reset: strict alternation starting at m0
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cur[0] = mk(1, 40 + i, 0, 4'hF, 0);
            cur[1] = mk(1, 50 + i, 0, 4'hF, 0);
            drive_all();
            #1 chk("contend_m0_gnt", 64'(m0_if.gnt), 64'(i % 2 == 0));
            step();
        end
        cur[0].req = 0;
        cur[1].req = 0;
        drive_all();
        step();

        // m1 partial write then back-to-back read of the same word
        cur[1] = mk(1, 16'h0020, 1, 4'b0011, 32'h12345678);
        drive_all();
        #1 chk("wr_gnt", 64'(m1_if.gnt), 64'(1));
        step();
        cur[1] = mk(1, 16'h0020, 0, 4'hF, 0);
        drive_all();
        chk("wr_rvalid", 64'(m1_if.rvalid), 64'(1));
        chk("wr_rdata_kept", 64'(m1_if.rdata), 64'(hold[1]));
        step();
        cur[1].req = 0;
        drive_all();
        chk("raw_rvalid", 64'(m1_if.rvalid), 64'(1));
        chk("raw_rdata", 64'(m1_if.rdata), 64'(32'hAAAA5678));

        // Lone m1 after m1 was last granted
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cur[1] = mk(1, 60 + i, 0, 4'hF, 0);
            drive_all();
            #1 chk("lone_gnt", 64'(m1_if.gnt), 64'(1));
            step();
            if (m1_if.rvalid) rv_cnt++;
        end
        chk("lone_rvalid_count", 64'(rv_cnt), 64'(4));
        cur[1].req = 0;
        drive_all();
        step();

        // Reset right after an m0 read is accepted
        cur[0] = mk(1, 16'h0010, 0, 4'hF, 0);
        drive_all();
        #2 model_check();
        @(posedge clk);
        commit();
        #1 rst = 1'b1;
        model_reset();
        #1 model_check();
        chk("midrst_m0_rvalid", 64'(m0_if.rvalid), 64'(0));
        chk("midrst_m0_rdata", 64'(m0_if.rdata), 64'(0));
        chk("midrst_mem_en", 64'(mem_en), 64'(0));
        @(posedge clk);
        #1 model_check();
        @(negedge clk);
        rst = 1'b0;
        cur[0] = mk(1, 70, 0, 4'hF, 0);
        cur[1] = mk(1, 71, 0, 4'hF, 0);
        drive_all();
        #1 chk("postrst_m0_first", 64'({m0_if.gnt, m1_if.gnt}), 64'(2'b10));
        step();
        cur[0].req = 0;
        drive_all();
        step();
        cur[1].req = 0;
        drive_all();
        step();

        // Random traffic: requests held until granted, occasionally dropped
        for (int n = 0; n < 400; n++) begin
            for (int x = 0; x < 2; x++) begin
                if (cur[x].req && $urandom_range(0, 15) == 0) begin
                    cur[x].req = 0;
                end else if (!cur[x].req && $urandom_range(0, 3) != 0) begin
                    cur[x] = mk(1, int'($urandom_range(0, 47)), 1'($urandom_range(0, 1)),
                                4'($urandom), $urandom);
                end
            end
            drive_all();
            step();
            if (win >= 0) cur[win].req = 0;
        end
        cur[0].req = 0;
        cur[1].req = 0;
        drive_all();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
